// File: rtl/spi_rx_burst.sv
// SPI burst receiver: regenerates serial_clock from clk_ic, assembles word_count words and
// hands them out through a valid/ready register. Optional abort timer: SPI_RX_BURST_TIMEOUT_EN.
module spi_rx_burst #(
  parameter int WIDTH     = 8,
  parameter int COUNT_W   = 8,
  parameter int LSB_FIRST = 0,
  parameter int CPOL      = 0,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_ic,
  input  logic               rd_en,
  input  logic [COUNT_W-1:0] word_count,
  input  logic               serial_in,
  output logic               serial_clock,
  output logic [WIDTH-1:0]   data_out,
  output logic               data_valid,
  input  logic               data_ready,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int   BIT_W    = $clog2(WIDTH + 1);
  localparam logic IDLE_LVL = (CPOL != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_SHIFT,
    S_STALL
  } state_t;

  state_t             state_q, state_d;
  logic               last_clk_ic_q, last_clk_ic_d;
  logic               serial_clock_q, serial_clock_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [COUNT_W-1:0] words_q, words_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               data_valid_q, data_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic lead_edge, trail_edge, load;

  assign lead_edge  = (last_clk_ic_q == IDLE_LVL) && (clk_ic == !IDLE_LVL);
  assign trail_edge = (last_clk_ic_q == !IDLE_LVL) && (clk_ic == IDLE_LVL);

`ifdef SPI_RX_BURST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    // NOTE: every signal gets its default first so no path through the case leaves a latch.
    state_d        = state_q;
    last_clk_ic_d  = clk_ic;
    serial_clock_d = serial_clock_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    words_d        = words_q;
    data_out_d     = data_out_q;
    data_valid_d   = data_valid_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    load           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rd_en) begin
          words_d   = word_count;
          bit_cnt_d = '0;
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_WAIT_EDGE;
            busy_d  = 1'b1;
          end
        end
      end
      S_WAIT_EDGE: begin
        if (lead_edge) begin
          serial_clock_d = !IDLE_LVL;
          if (LSB_FIRST != 0) shift_d = {serial_in, shift_q[WIDTH-1:1]};
          else                shift_d = {shift_q[WIDTH-2:0], serial_in};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (trail_edge) begin
          serial_clock_d = IDLE_LVL;
          if (bit_cnt_q < BIT_W'(WIDTH))          state_d = S_WAIT_EDGE;
          else if (!data_valid_q || data_ready)   load    = 1'b1;
          else                                    state_d = S_STALL;
        end
      end
      S_STALL: begin
        // clk_ic edges are deliberately dropped here; the IC keeps clocking regardless.
        if (data_ready) load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (data_valid_q && data_ready) data_valid_d = 1'b0;

    if (load) begin
      data_out_d   = shift_q;
      data_valid_d = 1'b1;
      words_d      = words_q - COUNT_W'(1);
      bit_cnt_d    = '0;
      if (words_q == COUNT_W'(1)) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = S_WAIT_EDGE;
      end
    end

`ifdef SPI_RX_BURST_TIMEOUT_EN
    timeout_d = 1'b0;
    tmo_cnt_d = '0;
    if ((state_q == S_WAIT_EDGE) || (state_q == S_SHIFT)) begin
      if (lead_edge || trail_edge) begin
        tmo_cnt_d = '0;
      end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
        // Abort drops the partial word but leaves any delivered word in data_out.
        state_d        = S_IDLE;
        serial_clock_d = IDLE_LVL;
        busy_d         = 1'b0;
        bit_cnt_d      = '0;
        timeout_d      = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      last_clk_ic_q  <= IDLE_LVL;
      serial_clock_q <= IDLE_LVL;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      words_q        <= '0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q        <= state_d;
      last_clk_ic_q  <= last_clk_ic_d;
      serial_clock_q <= serial_clock_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      words_q        <= words_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

`ifdef SPI_RX_BURST_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT;
  assign timeout              = 1'b0;
`endif

  assign serial_clock = serial_clock_q;
  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
